moore_seq_detector_param: RTL and testbench

//  Parametrised Moore-type serial sequence detector: watches the 1-bit stream inputW and

---
 rtl/moore_seq_detector_param.sv | 149 ++++++++++++++
 tb/tb_moore_seq_detector_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector: KMP-style prefix tracking of an arbitrary
// pattern, runtime overlap mode, sample enable and a saturating hit counter.
module moore_seq_detector_param #(
   parameter int          PAT_LEN = 4,
   parameter logic [15:0] PATTERN = 16'b0000_0000_0000_1011,
   parameter int          CNT_W   = 8,
   localparam int         SW      = $clog2(PAT_LEN + 1)
) (
   input  logic             inputClk,
   input  logic             inputReset,
   input  logic             inputW,
   input  logic             inputEnable,
   input  logic             inputOverlap,
   output logic             outputZ,
   output logic [SW-1:0]    outputState,
   output logic [CNT_W-1:0] outputCount
);

   localparam int TAB_N = 2 ** SW;

   // Pattern bit in arrival order: index 0 is the first bit received.
   function automatic logic pat_bit(input int idx);
      return PATTERN[4'(PAT_LEN - 1 - idx)];
   endfunction

   // Longest pattern prefix that is a suffix of (prefix of length s, then bit b).
   function automatic int calc_next(input int s, input logic b);
      int   best;
      int   pos;
      logic ok;
      logic ch;
      best = 0;
      for (int k = 1; k <= PAT_LEN; k++) begin
         ok = 1'b1;
         if (k > s + 1) begin
            ok = 1'b0;
         end else begin
            for (int i = 0; i < k; i++) begin
               pos = s + 1 - k + i;
               ch  = (pos < s) ? pat_bit(pos) : b;
               if (ch != pat_bit(i)) begin
                  ok = 1'b0;
               end else begin
                  ok = ok;
               end
            end
         end
         if (ok) begin
            best = k;
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

   // Longest proper suffix of the whole pattern that is also one of its prefixes.
   function automatic int calc_fail();
      int   best;
      logic ok;
      best = 0;
      for (int k = 1; k < PAT_LEN; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            if (pat_bit(PAT_LEN - k + i) != pat_bit(i)) begin
               ok = 1'b0;
            end else begin
               ok = ok;
            end
         end
         if (ok) begin
            best = k;
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

   localparam logic [SW-1:0]    FULL_S  = SW'(PAT_LEN);
   localparam logic [SW-1:0]    FAIL_S  = SW'(calc_fail());
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [TAB_N-1:0][SW-1:0] next0_s;
   logic [TAB_N-1:0][SW-1:0] next1_s;

   // Transition table is constant: each entry folds to a literal at elaboration.
   for (genvar gs = 0; gs < TAB_N; gs++) begin : g_tab
      if (gs < PAT_LEN) begin : g_live
         assign next0_s[gs] = SW'(calc_next(gs, 1'b0));
         assign next1_s[gs] = SW'(calc_next(gs, 1'b1));
      end else begin : g_pad
         assign next0_s[gs] = {SW{1'b0}};
         assign next1_s[gs] = {SW{1'b0}};
      end
   end

   logic [SW-1:0]    state_q, state_d;
   logic             z_q, z_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [SW-1:0]    base_s;
   logic [SW-1:0]    step_s;

   // Collapse a completed match (overlap-dependent), then take one step on the sampled bit.
   always_comb begin
      base_s  = state_q;
      step_s  = {SW{1'b0}};
      state_d = state_q;
      z_d     = z_q;
      count_d = count_q;
      if (state_q == FULL_S) begin
         base_s = inputOverlap ? FAIL_S : {SW{1'b0}};
      end else begin
         base_s = state_q;
      end
      step_s = inputW ? next1_s[base_s] : next0_s[base_s];
      if (inputEnable) begin
         state_d = step_s;
         z_d     = (step_s == FULL_S);
         if ((step_s == FULL_S) && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_d = count_q;
         end
      end else begin
         state_d = state_q;
         z_d     = z_q;
         count_d = count_q;
      end
   end

   // State, Moore output and hit counter registers; reset wins over enable.
   always_ff @(posedge inputClk) begin
      if (inputReset) begin
         state_q <= {SW{1'b0}};
         z_q     <= 1'b0;
         count_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         count_q <= count_d;
      end
   end

   assign outputZ     = z_q;
   assign outputState = state_q;
   assign outputCount = count_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Bench for moore_seq_detector_param: directed vector table, hand-written corner sequences
// and a randomized run against a history-based reference model, on three configurations.
module tb_moore_seq_detector_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic in_reset = 1'b1;
   logic in_w = 1'b0;
   logic in_en = 1'b0;
   logic in_ov = 1'b0;

   logic       z_a, z_b, z_c;
   logic [2:0] st_a;
   logic [1:0] st_b, st_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;

   int checks = 0;
   int failures = 0;

   moore_seq_detector_param #(.PAT_LEN(4), .PATTERN(16'b1011), .CNT_W(8)) dut_a (
      .inputClk(clk), .inputReset(in_reset), .inputW(in_w), .inputEnable(in_en),
      .inputOverlap(in_ov), .outputZ(z_a), .outputState(st_a), .outputCount(cnt_a));

   moore_seq_detector_param #(.PAT_LEN(3), .PATTERN(16'b111), .CNT_W(8)) dut_b (
      .inputClk(clk), .inputReset(in_reset), .inputW(in_w), .inputEnable(in_en),
      .inputOverlap(in_ov), .outputZ(z_b), .outputState(st_b), .outputCount(cnt_b));

   moore_seq_detector_param #(.PAT_LEN(3), .PATTERN(16'b111), .CNT_W(2)) dut_c (
      .inputClk(clk), .inputReset(in_reset), .inputW(in_w), .inputEnable(in_en),
      .inputOverlap(in_ov), .outputZ(z_c), .outputState(st_c), .outputCount(cnt_c));

   // Reference model: keeps the recent bit history and searches it for the longest
   // suffix that is a pattern prefix.
   int          m_plen [3] = '{4, 3, 3};
   logic [15:0] m_pat  [3] = '{16'b1011, 16'b111, 16'b111};
   int          m_cmax [3] = '{255, 255, 3};
   logic [15:0] m_hist [3];
   int          m_hlen [3];
   int          m_st   [3];
   int          m_cnt  [3];

   function automatic int longest(input logic [15:0] h, input int hl, input int plen,
                                  input logic [15:0] pat);
      int best = 0;
      logic [15:0] mask;
      logic [15:0] want;
      for (int k = 1; k <= plen; k++) begin
         if (k <= hl) begin
            mask = (16'h1 << k) - 16'h1;
            want = (pat >> (plen - k)) & mask;
            if ((h & mask) == want) best = k;
         end
      end
      return best;
   endfunction

   task automatic model_update(input bit rst, input bit w, input bit en, input bit ov);
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            m_hist[m] = 16'h0; m_hlen[m] = 0; m_st[m] = 0; m_cnt[m] = 0;
         end else if (en) begin
            if (m_st[m] == m_plen[m] && !ov) begin
               m_hist[m] = 16'h0; m_hlen[m] = 0;
            end
            m_hist[m] = {m_hist[m][14:0], w};
            if (m_hlen[m] < 16) m_hlen[m]++;
            m_st[m] = longest(m_hist[m], m_hlen[m], m_plen[m], m_pat[m]);
            if (m_st[m] == m_plen[m] && m_cnt[m] < m_cmax[m]) m_cnt[m]++;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic step(input bit rst, input bit w, input bit en, input bit ov);
      in_reset = rst; in_w = w; in_en = en; in_ov = ov;
      @(posedge clk);
      model_update(rst, w, en, ov);
      #1;
      check("a_state", 32'(st_a), m_st[0]);
      check("a_z", 32'(z_a), (m_st[0] == 4) ? 1 : 0);
      check("a_count", 32'(cnt_a), m_cnt[0]);
      check("b_state", 32'(st_b), m_st[1]);
      check("b_z", 32'(z_b), (m_st[1] == 3) ? 1 : 0);
      check("b_count", 32'(cnt_b), m_cnt[1]);
      check("c_state", 32'(st_c), m_st[2]);
      check("c_z", 32'(z_c), (m_st[2] == 3) ? 1 : 0);
      check("c_count", 32'(cnt_c), m_cnt[2]);
   endtask

   typedef struct {
      bit rst; bit w; bit en; bit ov;
      int st; int z; int cnt;
   } vec_t;
   vec_t tab[$];

   task automatic add(input bit rst, input bit w, input bit en, input bit ov,
                      input int st, input int z, input int cnt);
      vec_t v;
      v.rst = rst; v.w = w; v.en = en; v.ov = ov; v.st = st; v.z = z; v.cnt = cnt;
      tab.push_back(v);
   endtask

   initial begin
      // Reset held with W toggling
      add(1, 1, 1, 1, 0, 0, 0);
      add(1, 0, 1, 1, 0, 0, 0);
      // 1011 overlapping: 1,0,1,1,0,1,1
      add(0, 1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 1, 2, 0, 0);
      add(0, 1, 1, 1, 3, 0, 0);
      add(0, 1, 1, 1, 4, 1, 1);
      add(0, 0, 1, 1, 2, 0, 1);
      add(0, 1, 1, 1, 3, 0, 1);
      add(0, 1, 1, 1, 4, 1, 2);
      // Same stream, non-overlapping
      add(1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 0);
      add(0, 0, 1, 0, 2, 0, 0);
      add(0, 1, 1, 0, 3, 0, 0);
      add(0, 1, 1, 0, 4, 1, 1);
      add(0, 0, 1, 0, 0, 0, 1);
      add(0, 1, 1, 0, 1, 0, 1);
      add(0, 1, 1, 0, 1, 0, 1);
      // Enable gap between bits 2 and 3, then hold while matched
      add(1, 0, 1, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 0, 0);
      add(0, 0, 1, 1, 2, 0, 0);
      add(0, 0, 0, 1, 2, 0, 0);
      add(0, 0, 0, 1, 2, 0, 0);
      add(0, 0, 0, 1, 2, 0, 0);
      add(0, 1, 1, 1, 3, 0, 0);
      add(0, 1, 1, 1, 4, 1, 1);
      add(0, 0, 0, 0, 4, 1, 1);
      add(0, 1, 0, 1, 4, 1, 1);

      for (int i = 0; i < tab.size(); i++) begin
         step(tab[i].rst, tab[i].w, tab[i].en, tab[i].ov);
         check("tab_state", 32'(st_a), tab[i].st);
         check("tab_z", 32'(z_a), tab[i].z);
         check("tab_count", 32'(cnt_a), tab[i].cnt);
      end

      // Pattern 111, overlapping: five ones give three consecutive hits
      step(1, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 1);
         check("p111_ov_z", 32'(z_b), (i >= 2) ? 1 : 0);
      end
      check("p111_ov_count", 32'(cnt_b), 3);

      // Pattern 111, non-overlapping: states 1,2,3,1,2
      step(1, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 0);
         check("p111_nov_state", 32'(st_b), (i < 3) ? i + 1 : i - 2);
      end
      check("p111_nov_count", 32'(cnt_b), 1);

      // Two-bit counter saturates at 3
      step(1, 0, 1, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
      check("sat_count", 32'(cnt_c), 3);
      check("sat_count_b", 32'(cnt_b), 6);

      // Reset mid-sequence at state 2 discards the partial match
      step(1, 0, 1, 1);
      step(0, 1, 1, 1);
      step(0, 1, 1, 1);
      check("mid_pre_state", 32'(st_c), 2);
      step(1, 1, 1, 1);
      check("mid_rst_state", 32'(st_c), 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 1);
         check("mid_after_state", 32'(st_c), i + 1);
         check("mid_after_z", 32'(z_c), (i == 2) ? 1 : 0);
      end

      // Randomized stream against the reference model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 7) != 0),
              1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
